// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with a start/busy/done handshake.
// Processes one multiplier bit per clock and returns a full 2*WIDTH-bit
// product in either unsigned or two's-complement mode.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   start       request; accepted only when no operation is running
//   a           multiplicand, captured when start is accepted
//   b           multiplier, captured when start is accepted
//   signed_mode 1 = two's-complement operands, 0 = unsigned; captured with start
//   busy        high while an operation is in progress
//   done        one-cycle pulse when product becomes valid
//   product     result register; holds its value until the next done
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   sum;
  logic                 last;

  // Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1)
  // without overflow.
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    sum   = acc + (mplier[0] ? mcand : '0);
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // FINISH accepts a new start exactly like IDLE so that
        // back-to-back operations need no gap cycle.
        IDLE, FINISH: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The final partial sum goes straight into product so that done
          // lands WIDTH cycles after acceptance; a zero magnitude negates
          // to zero, so no negative zero can appear.
          if (last) begin
            state   <= FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= neg ? -sum : sum;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Expected products are pushed to a per-instance queue when start is driven
// and popped when the instance raises done.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        sm4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        sm8;
  logic        busy8, done8;
  logic [15:0] prod8;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .signed_mode(sm4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .product(prod8)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  function automatic logic [7:0] model4(logic [3:0] x, logic [3:0] y, logic s);
    int sx, sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return 8'(sx * sy);
  endfunction

  function automatic logic [15:0] model8(logic [7:0] x, logic [7:0] y, logic s);
    int sx, sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  // Observation only: waits for done (bounded), reports cycles from the
  // start negedge, number of busy cycles seen and any busy&&done overlap.
  task automatic wait_done4(input int maxc, input bit drop, output int cyc,
                            output int bn, output bit both);
    cyc = 0; bn = 0; both = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 1) start4 = 1'b0;
      if (busy4 === 1'b1) bn++;
      if (busy4 === 1'b1 && done4 === 1'b1) both = 1'b1;
    end while (done4 !== 1'b1 && cyc < maxc);
  endtask

  task automatic wait_done8(input int maxc, input bit drop, output int cyc,
                            output int bn, output bit both);
    cyc = 0; bn = 0; both = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 1) start8 = 1'b0;
      if (busy8 === 1'b1) bn++;
      if (busy8 === 1'b1 && done8 === 1'b1) both = 1'b1;
    end while (done8 !== 1'b1 && cyc < maxc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_w4: busy=%b done=%b product=%h required 0 0 00", busy4, done4, prod4);
    end
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_w8: busy=%b done=%b product=%h required 0 0 0000", busy8, done8, prod8);
    end
  endtask

  task automatic test_unsigned_hold();
    int cyc, bn, extra;
    bit both;
    logic [7:0] exp;
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; start4 = 1'b1;
    q4.push_back(8'hE1);
    wait_done4(20, 1'b1, cyc, bn, both);
    exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
    vectors++;
    if (done4 !== 1'b1 || prod4 !== exp) begin
      miscompares++;
      $display("FAIL umax_product: done=%b product=%h required 1 %h", done4, prod4, exp);
    end
    vectors++;
    if (cyc != 5 || bn != 4 || both) begin
      miscompares++;
      $display("FAIL umax_timing: done_cycle=%0d busy_cycles=%0d overlap=%b required 5 4 0", cyc, bn, both);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) extra++;
    end
    vectors++;
    if (prod4 !== 8'hE1 || extra != 0) begin
      miscompares++;
      $display("FAIL umax_hold: product=%h stray_busy_or_done=%0d required e1 0", prod4, extra);
    end
  endtask

  task automatic test_signed_mode();
    logic [3:0] ta[11];
    logic [3:0] tb_v[11];
    logic       ts[11];
    logic [7:0] te[11];
    logic [7:0] exp;
    int cyc, bn;
    bit both;
    ta[0] = 4'h8; tb_v[0] = 4'h8; ts[0] = 1'b1; te[0] = 8'h40;
    ta[1] = 4'hD; tb_v[1] = 4'h5; ts[1] = 1'b1; te[1] = 8'hF1;
    ta[2] = 4'h0; tb_v[2] = 4'hF; ts[2] = 1'b1; te[2] = 8'h00;
    ta[3] = 4'hD; tb_v[3] = 4'h5; ts[3] = 1'b0; te[3] = 8'h41;
    ta[4] = 4'hD; tb_v[4] = 4'h5; ts[4] = 1'b1; te[4] = 8'hF1;
    for (int i = 5; i < 11; i++) begin
      ta[i]   = 4'($urandom_range(0, 15));
      tb_v[i] = 4'($urandom_range(0, 15));
      ts[i]   = 1'($urandom_range(0, 1));
      te[i]   = model4(ta[i], tb_v[i], ts[i]);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a4 = ta[i]; b4 = tb_v[i]; sm4 = ts[i]; start4 = 1'b1;
      q4.push_back(te[i]);
      wait_done4(20, 1'b1, cyc, bn, both);
      exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
      vectors++;
      if (done4 !== 1'b1 || prod4 !== exp) begin
        miscompares++;
        $display("FAIL mode_product[%0d] a=%h b=%h signed=%b: done=%b product=%h required 1 %h",
                 i, ta[i], tb_v[i], ts[i], done4, prod4, exp);
      end
      vectors++;
      if (cyc != 5 || bn != 4 || both) begin
        miscompares++;
        $display("FAIL mode_timing[%0d]: done_cycle=%0d busy_cycles=%0d overlap=%b required 5 4 0",
                 i, cyc, bn, both);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone, first;
    logic [7:0] exp;
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd3; sm4 = 1'b0; start4 = 1'b1;
    q4.push_back(8'd9);
    ndone = 0; first = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = c;
          exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
          vectors++;
          if (prod4 !== exp) begin
            miscompares++;
            $display("FAIL ignore_product: product=%h required %h", prod4, exp);
          end
        end
      end
      if (c == 1) start4 = 1'b0;
      if (c == 2) begin start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; end
      if (c == 3) begin start4 = 1'b0; a4 = 4'd1; b4 = 4'd2; sm4 = 1'b1; end
    end
    vectors++;
    if (ndone != 1 || first != 5) begin
      miscompares++;
      $display("FAIL ignore_done: pulses=%0d first_cycle=%0d required 1 5", ndone, first);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    bit both;
    logic [7:0] exp;
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd3; sm4 = 1'b0; start4 = 1'b1;
    q4.push_back(8'd6);
    wait_done4(20, 1'b1, cyc, bn, both);
    exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
    vectors++;
    if (done4 !== 1'b1 || prod4 !== exp || cyc != 5) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b product=%h cycle=%0d required 1 %h 5", done4, prod4, cyc, exp);
    end
    // Still in the done cycle: request the next operation immediately.
    a4 = 4'd4; b4 = 4'd5; start4 = 1'b1;
    q4.push_back(8'd20);
    wait_done4(20, 1'b1, cyc, bn, both);
    exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
    vectors++;
    if (done4 !== 1'b1 || prod4 !== exp) begin
      miscompares++;
      $display("FAIL b2b_second_product: done=%b product=%h required 1 %h", done4, prod4, exp);
    end
    vectors++;
    if (cyc != 5 || bn != 4 || both) begin
      miscompares++;
      $display("FAIL b2b_second_timing: done_cycle=%0d busy_cycles=%0d overlap=%b required 5 4 0", cyc, bn, both);
    end
  endtask

  task automatic test_reset_mid_run4();
    int cyc, bn, stray;
    bit both;
    logic [7:0] exp;
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid_w4: busy=%b done=%b product=%h required 0 0 00", busy4, done4, prod4);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL rst_mid_w4_quiet: stray_cycles=%0d required 0", stray);
    end
    a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    q4.push_back(8'd42);
    wait_done4(20, 1'b1, cyc, bn, both);
    exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
    vectors++;
    if (done4 !== 1'b1 || prod4 !== exp || cyc != 5) begin
      miscompares++;
      $display("FAIL rst_mid_w4_after: done=%b product=%h cycle=%0d required 1 %h 5", done4, prod4, cyc, exp);
    end
  endtask

  task automatic test_width8();
    logic [7:0]  ta[7];
    logic [7:0]  tb_v[7];
    logic        ts[7];
    logic [15:0] te[7];
    logic [15:0] exp;
    int cyc, bn;
    bit both;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_mid_w8: busy=%b done=%b product=%h required 0 0 0000", busy8, done8, prod8);
    end
    ta[0] = 8'hFF; tb_v[0] = 8'hFF; ts[0] = 1'b0; te[0] = 16'hFE01;
    ta[1] = 8'h80; tb_v[1] = 8'h80; ts[1] = 1'b1; te[1] = 16'h4000;
    ta[2] = 8'h00; tb_v[2] = 8'h80; ts[2] = 1'b1; te[2] = 16'h0000;
    for (int i = 3; i < 7; i++) begin
      ta[i]   = 8'($urandom_range(0, 255));
      tb_v[i] = 8'($urandom_range(0, 255));
      ts[i]   = 1'($urandom_range(0, 1));
      te[i]   = model8(ta[i], tb_v[i], ts[i]);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a8 = ta[i]; b8 = tb_v[i]; sm8 = ts[i]; start8 = 1'b1;
      q8.push_back(te[i]);
      wait_done8(30, 1'b1, cyc, bn, both);
      exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
      vectors++;
      if (done8 !== 1'b1 || prod8 !== exp) begin
        miscompares++;
        $display("FAIL w8_product[%0d] a=%h b=%h signed=%b: done=%b product=%h required 1 %h",
                 i, ta[i], tb_v[i], ts[i], done8, prod8, exp);
      end
      vectors++;
      if (cyc != 9 || bn != 8 || both) begin
        miscompares++;
        $display("FAIL w8_timing[%0d]: done_cycle=%0d busy_cycles=%0d overlap=%b required 9 8 0",
                 i, cyc, bn, both);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_hold();
    test_signed_mode();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run4();
    test_width8();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
